// File: rtl/adc_capture_pkg.sv
// Shared state encoding and default widths for the ADC capture block.
package adc_capture_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} adc_capture_state_t;

    localparam int ADC_CAPTURE_DATA_WIDTH = 64;
    localparam int ADC_CAPTURE_ADDR_WIDTH = 13;

endpackage

// File: rtl/adc_capture_bram.sv
// Captures triggered ADC stream beats into a host BRAM port, one beat per word; optional
// early stop on tlast when ADC_CAPTURE_TLAST_STOP_EN is defined.
// Latency: BRAM write one cycle after the accepted beat. Backpressure: none, tready is always 1.
module adc_capture_bram
    import adc_capture_pkg::*;
#(
    parameter int DATA_WIDTH = ADC_CAPTURE_DATA_WIDTH,
    parameter int ADDR_WIDTH = ADC_CAPTURE_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    trig,
    input  logic [ADDR_WIDTH:0]     len,
    input  logic                    s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    output logic [DATA_WIDTH-1:0]   bram_din,
    output logic                    bram_en,
    output logic [DATA_WIDTH/8-1:0] bram_we,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH:0]     wcount,
    output logic                    gap
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [CW-1:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    adc_capture_state_t state_q, state_d;

    logic [CW-1:0]         wcount_q;
    logic [CW-1:0]         len_q;
    logic                  gap_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_dat_q;

    logic          arm;
    logic          wr_fire;
    logic          gap_set;
    logic          tlast_stop;
    logic [CW-1:0] wcount_inc;
    logic [CW-1:0] len_eff;

`ifdef ADC_CAPTURE_TLAST_STOP_EN
    assign tlast_stop = s_axis_tlast;
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
    assign tlast_stop   = 1'b0;
`endif

    assign wcount_inc = wcount_q + ONE;
    assign len_eff    = (len == '0) ? DEPTH : len;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // start outranks everything, including a beat that would have been the final write
    always_comb begin
        state_d = state_q;
        arm     = 1'b0;
        wr_fire = 1'b0;
        gap_set = 1'b0;
        if (start) begin
            state_d = ARMED;
            arm     = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: ;
                ARMED: begin
                    if (trig) state_d = CAPTURE;
                end
                CAPTURE: begin
                    if (s_axis_tvalid) begin
                        wr_fire = 1'b1;
                        if (wcount_inc == len_q || tlast_stop) state_d = DONE;
                    end else begin
                        gap_set = 1'b1;
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcount_q  <= '0;
            len_q     <= '0;
            gap_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_dat_q  <= '0;
        end else begin
            wr_en_q <= wr_fire;
            if (arm) begin
                wcount_q <= '0;
                gap_q    <= 1'b0;
                len_q    <= len_eff;
            end else begin
                if (wr_fire) begin
                    wcount_q  <= wcount_inc;
                    wr_addr_q <= wcount_q[ADDR_WIDTH-1:0];
                    wr_dat_q  <= s_axis_tdata;
                end
                if (gap_set) gap_q <= 1'b1;
            end
        end
    end

    assign s_axis_tready = 1'b1;
    assign bram_addr     = wr_addr_q;
    assign bram_din      = wr_dat_q;
    assign bram_en       = wr_en_q;
    assign bram_we       = {(DATA_WIDTH/8){wr_en_q}};
    assign busy          = (state_q == ARMED) || (state_q == CAPTURE);
    assign done          = (state_q == DONE);
    assign wcount        = wcount_q;
    assign gap           = gap_q;

endmodule

// File: tb/tb_adc_capture_bram.sv
// Scoreboard bench for adc_capture_bram built with a 16-word buffer.
module tb_adc_capture_bram;

    localparam int DW = 64;
    localparam int AW = 4;
    localparam int CW = AW + 1;

    logic          clk = 1'b0;
    logic          rst, start, trig, tvalid, tlast, tready;
    logic [CW-1:0] len;
    logic [DW-1:0] tdata;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic          bram_en;
    logic [DW/8-1:0] bram_we;
    logic          busy, done, gap;
    logic [CW-1:0] wcount;

    always #5 clk = ~clk;

    adc_capture_bram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .trig(trig), .len(len),
        .s_axis_tvalid(tvalid), .s_axis_tdata(tdata), .s_axis_tlast(tlast),
        .s_axis_tready(tready), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_en(bram_en), .bram_we(bram_we), .busy(busy), .done(done),
        .wcount(wcount), .gap(gap)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            exp_n = 0;
    logic [DW-1:0] dcnt;
    bit            mon_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one stream cycle; wr says whether this beat must land in the BRAM
    task automatic send(input bit v, input bit wr);
        tvalid = v;
        tdata  = dcnt;
        if (v && wr) begin
            exp_q.push_back('{addr: AW'(exp_n), data: dcnt});
            exp_n++;
        end
        dcnt++;
        step();
    endtask

    task automatic arm(input logic [CW-1:0] l);
        start  = 1'b1;
        len    = l;
        tvalid = 1'b0;
        step();
        start  = 1'b0;
        exp_n  = 0;
    endtask

    task automatic fire_trig();
        trig = 1'b1;
        send(1'b1, 1'b0);
        trig = 1'b0;
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (mon_en) begin
            if (bram_en) begin
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected", 64'(bram_addr), 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(bram_addr), 64'(e.addr));
                    chk("wr_data", bram_din, e.data);
                    chk("wr_we", 64'(bram_we), 64'hFF);
                end
            end else begin
                chk("we_idle", 64'(bram_we), 64'h0);
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; trig = 1'b0; len = '0;
        tvalid = 1'b0; tdata = '0; tlast = 1'b0;
        dcnt = 64'h100;
        step();
        step();
        mon_en = 1'b1;
        chk("rst_tready", 64'(tready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_wcount", 64'(wcount), 64'd0);
        chk("rst_gap", 64'(gap), 64'd0);
        chk("rst_en", 64'(bram_en), 64'd0);
        rst = 1'b0;
        step();

        // basic capture, len=4
        arm(5'd4);
        chk("arm_busy", 64'(busy), 64'd1);
        dcnt = 64'h100;
        fire_trig();
        repeat (4) send(1'b1, 1'b1);
        repeat (3) send(1'b1, 1'b0);
        chk("basic_done", 64'(done), 64'd1);
        chk("basic_busy", 64'(busy), 64'd0);
        chk("basic_wcount", 64'(wcount), 64'd4);
        chk("basic_gap", 64'(gap), 64'd0);
        chk("basic_q", 64'(exp_q.size()), 64'd0);
        // trig in DONE does nothing
        fire_trig();
        repeat (2) send(1'b1, 1'b0);
        chk("done_trig_wcount", 64'(wcount), 64'd4);
        chk("done_trig_done", 64'(done), 64'd1);

        // full depth via len=0
        arm(5'd0);
        chk("full_done_clr", 64'(done), 64'd0);
        chk("full_wcount_clr", 64'(wcount), 64'd0);
        fire_trig();
        repeat (16) send(1'b1, 1'b1);
        repeat (2) send(1'b1, 1'b0);
        chk("full_done", 64'(done), 64'd1);
        chk("full_wcount", 64'(wcount), 64'd16);
        chk("full_q", 64'(exp_q.size()), 64'd0);

        // gap, len=8
        arm(5'd8);
        fire_trig();
        repeat (3) send(1'b1, 1'b1);
        repeat (2) send(1'b0, 1'b0);
        chk("gap_set_mid", 64'(gap), 64'd1);
        repeat (5) send(1'b1, 1'b1);
        repeat (2) send(1'b1, 1'b0);
        chk("gap_flag", 64'(gap), 64'd1);
        chk("gap_done", 64'(done), 64'd1);
        chk("gap_wcount", 64'(wcount), 64'd8);

        // re-arm after 3 of 10 words
        arm(5'd10);
        chk("rearm_gap_clr", 64'(gap), 64'd0);
        fire_trig();
        repeat (3) send(1'b1, 1'b1);
        start = 1'b1;
        send(1'b1, 1'b0);
        start = 1'b0;
        exp_n = 0;
        chk("rearm_busy", 64'(busy), 64'd1);
        chk("rearm_wcount", 64'(wcount), 64'd0);
        repeat (2) send(1'b1, 1'b0);
        fire_trig();
        repeat (9) send(1'b1, 1'b1);
        chk("rearm_not_done", 64'(done), 64'd0);
        chk("rearm_wcount9", 64'(wcount), 64'd9);
        send(1'b1, 1'b1);
        repeat (2) send(1'b1, 1'b0);
        chk("rearm_done", 64'(done), 64'd1);
        chk("rearm_wcount10", 64'(wcount), 64'd10);

        // start coincides with the final beat
        arm(5'd2);
        fire_trig();
        send(1'b1, 1'b1);
        start = 1'b1;
        send(1'b1, 1'b0);
        start = 1'b0;
        exp_n = 0;
        chk("race_busy", 64'(busy), 64'd1);
        chk("race_done", 64'(done), 64'd0);
        chk("race_wcount", 64'(wcount), 64'd0);
        fire_trig();
        repeat (2) send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        chk("race_done2", 64'(done), 64'd1);
        chk("race_wcount2", 64'(wcount), 64'd2);

        // reset mid-capture
        arm(5'd8);
        fire_trig();
        repeat (2) send(1'b1, 1'b1);
        rst = 1'b1;
        send(1'b1, 1'b0);
        rst = 1'b0;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_en", 64'(bram_en), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        chk("mrst_wcount", 64'(wcount), 64'd0);
        chk("mrst_tready", 64'(tready), 64'd1);
        fire_trig();
        repeat (3) send(1'b1, 1'b0);
        chk("idle_trig_busy", 64'(busy), 64'd0);
        chk("idle_trig_wcount", 64'(wcount), 64'd0);

`ifdef ADC_CAPTURE_TLAST_STOP_EN
        arm(5'd8);
        fire_trig();
        repeat (4) send(1'b1, 1'b1);
        tlast = 1'b1;
        send(1'b1, 1'b1);
        tlast = 1'b0;
        repeat (3) send(1'b1, 1'b0);
        chk("tlast_done", 64'(done), 64'd1);
        chk("tlast_wcount", 64'(wcount), 64'd5);
`endif

        tvalid = 1'b0;
        step();
        step();
        chk("final_q", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adc_capture_bram.md
Name: adc_capture_bram

Overview:
- AXI4-stream receiver that captures ADC sample words into a host-readable BRAM port (the to-host BRAM), one stream beat per BRAM word.
- Sits between the ADC20 AXIS slave stream and a BRAM_TOHOST port.
- The host arms it via local-bus registers; a hardware trigger starts the capture.
- The host polls busy/done and then reads the buffer.

Parameters:
- DATA_WIDTH, 64: stream tdata and BRAM word width in bits; multiple of 8.
- ADDR_WIDTH, 13: BRAM word-address width; depth is 2^ADDR_WIDTH words.

Ports:
- clk  input  1  capture clock; stream and BRAM port both in this domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle arm pulse from the control register.
- trig  input  1  capture trigger; level-sampled while armed.
- len  input  ADDR_WIDTH+1  words to capture; 0 means full depth; sampled at start.
- s_axis_tvalid  input  1  stream valid.
- s_axis_tdata  input  DATA_WIDTH  stream data.
- s_axis_tlast  input  1  stream last; used only with the optional feature.
- s_axis_tready  output  1  stream ready.
- bram_addr  output  ADDR_WIDTH  BRAM word address.
- bram_din  output  DATA_WIDTH  BRAM write data.
- bram_en  output  1  BRAM enable.
- bram_we  output  DATA_WIDTH/8  BRAM byte write enables.
- busy  output  1  armed or capturing.
- done  output  1  capture complete; sticky.
- wcount  output  ADDR_WIDTH+1  words written so far.
- gap  output  1  sticky flag: tvalid was low during capture.

Behaviour:
- Reset values: state IDLE; all outputs 0 except s_axis_tready = 1. Reset mid-capture aborts the capture; BRAM contents are not cleared.
- s_axis_tready is 1 in every state. The ADC stream is never back-pressured; beats arriving outside CAPTURE are discarded.
- State IDLE:
  - start -> ARMED.
  - On start: latch len_r = (len==0) ? 2^ADDR_WIDTH : len; clear wcount, done and gap.
- State ARMED:
  - trig=1 -> CAPTURE.
  - The beat accepted in the cycle trig is seen is not written; the first written beat is the one in the following cycle.
- State CAPTURE:
  - Each cycle with tvalid=1, register a write with bram_en=1, bram_we=all ones, bram_addr=wcount[ADDR_WIDTH-1:0], bram_din=tdata. Then increment wcount.
  - BRAM write signals are registered: they appear one cycle after the accepted beat. In cycles with no write, bram_en and bram_we are 0.
  - tvalid=0 in CAPTURE sets gap; gap stays set until the next start.
  - When the write that makes wcount == len_r is issued -> DONE.
  - No address wrap ever occurs, since len_r ≤ depth.
- State DONE:
  - done=1 and busy=0; no further writes.
  - start -> ARMED, with the same latching as in IDLE.
- busy = (state==ARMED || state==CAPTURE).
- start while busy aborts and re-arms: wcount, done and gap are cleared, and the BRAM write pending in that cycle is dropped.
- start in the same cycle as the final beat: start wins; that final beat is not written.
- trig while in IDLE or DONE is ignored.
- wcount counts to len_r exactly and saturates; arithmetic is unsigned at width ADDR_WIDTH+1.

Optional Feature:
- Macro: ADC_CAPTURE_TLAST_STOP_EN.
- Defined: in CAPTURE, a written beat with tlast=1 ends the capture early -> DONE after that write, even if wcount < len_r.
- Not defined: tlast is ignored, and its port remains present but unused.

Decomposition:
- Package adc_capture_pkg holds:
  - typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} adc_capture_state_t;
  - default width constants ADC_CAPTURE_DATA_WIDTH = 64 and ADC_CAPTURE_ADDR_WIDTH = 13.
- Single module; no sub-module is warranted. The FSM, counter and write register stage fit in one block.

Test Plan:
- Basic capture:
  - Stimulus: len=4, start, trig one cycle later, tvalid held 1 with incrementing tdata 0x100…
  - Response: exactly 4 writes to addresses 0..3 with the beats after the trig cycle. done=1 and wcount=4 one cycle after the last write; gap=0.
- Full depth with len=0:
  - Stimulus: ADDR_WIDTH=4 build, len=0, continuous valid.
  - Response: 16 writes to addresses 0..15, no wrap, done=1, wcount=16.
- Gap:
  - Stimulus: len=8, tvalid low for 2 cycles mid-capture.
  - Response: gap=1, still 8 writes at contiguous addresses 0..7, no writes during the low cycles.
- Re-arm:
  - Stimulus: start pulse after 3 of 10 words are written.
  - Response: busy stays 1, wcount returns to 0, the next trig restarts writes at address 0, done only after 10 new writes.
- Reset mid-capture:
  - Stimulus: rst for 1 cycle during CAPTURE.
  - Response: next cycle state IDLE, bram_en=0, done=0, wcount=0, s_axis_tready=1. A later trig produces no writes.
- TLAST stop (with the macro defined):
  - Stimulus: len=8, tlast on the 5th written beat.
  - Response: 5 writes, done=1, wcount=5.
